// File: rtl/apb3_csr_bank.sv
// APB3 control/status register bank: R/W control words, read-only status words,
// sticky W1C events with interrupt, self-clearing pulse word and a constant ID.
module apb3_csr_bank #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_CTRL    = 8,
    parameter int unsigned NUM_STAT    = 10,
    parameter int unsigned NUM_EVT     = 8,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hABCD_5678
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    output logic                           PREADY,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PSLVERROR,
    output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_out,
    output logic [NUM_CTRL-1:0]            ctrl_wr_stb,
    input  logic [NUM_STAT*DATA_WIDTH-1:0] stat_in,
    input  logic [NUM_EVT-1:0]             evt_in,
    output logic [DATA_WIDTH-1:0]          pulse_out,
    output logic                           irq
);

    localparam int unsigned IW = ADDR_WIDTH - 2;
    localparam int unsigned CW = 4;
    localparam logic [IW-1:0] IDX_STAT   = IW'(NUM_CTRL);
    localparam logic [IW-1:0] IDX_EVT_ST = IW'(NUM_CTRL + NUM_STAT);
    localparam logic [IW-1:0] IDX_EVT_EN = IW'(NUM_CTRL + NUM_STAT + 1);
    localparam logic [IW-1:0] IDX_PULSE  = IW'(NUM_CTRL + NUM_STAT + 2);
    localparam logic [IW-1:0] IDX_ID     = IW'(NUM_CTRL + NUM_STAT + 3);

    logic [NUM_CTRL-1:0][DATA_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [NUM_STAT-1:0][DATA_WIDTH-1:0] stat_w;
    logic [NUM_CTRL-1:0]                 stb_q, stb_d;
    logic [NUM_EVT-1:0]                  evt_st_q, evt_st_d;
    logic [NUM_EVT-1:0]                  evt_en_q, evt_en_d;
    logic [DATA_WIDTH-1:0]               pulse_q, pulse_d;
    logic                                irq_q, irq_d;
    logic [CW-1:0]                       cnt_q, cnt_d;

    logic [IW-1:0]         idx_c;
    logic                  acc_c;
    logic                  is_stat_c;
    logic                  err_c;
    logic                  wr_c;
    logic [DATA_WIDTH-1:0] rdata_c;

    assign stat_w    = stat_in;
    assign idx_c     = PADDR[ADDR_WIDTH-1:2];
    assign acc_c     = PSEL && PENABLE;
    assign is_stat_c = (idx_c >= IDX_STAT) && (idx_c < IDX_EVT_ST);
    assign err_c     = (PADDR[1:0] != 2'b00) || (idx_c > IDX_ID) ||
                       (PWRITE && (is_stat_c || (idx_c == IDX_ID)));
    assign PREADY    = acc_c && (cnt_q == CW'(WAIT_STATES));
    assign wr_c      = PREADY && PWRITE && !err_c;
    assign PSLVERROR = PREADY && err_c;
    assign PRDATA    = (PREADY && !err_c) ? rdata_c : '0;

    // Read mux; PULSE and unmapped words read as zero.
    always_comb begin
        rdata_c = '0;
        for (int unsigned k = 0; k < NUM_CTRL; k++) begin
            if (idx_c == IW'(k)) rdata_c = ctrl_q[k];
        end
        for (int unsigned k = 0; k < NUM_STAT; k++) begin
            if (idx_c == IW'(NUM_CTRL + k)) rdata_c = stat_w[k];
        end
        if (idx_c == IDX_EVT_ST) rdata_c = DATA_WIDTH'(evt_st_q);
        if (idx_c == IDX_EVT_EN) rdata_c = DATA_WIDTH'(evt_en_q);
        if (idx_c == IDX_ID)     rdata_c = ID_VALUE;
    end

    // Next-state: write commit, sticky events (set wins over W1C), wait counter.
    always_comb begin
        logic [NUM_EVT-1:0] evt_clr;
        ctrl_d   = ctrl_q;
        stb_d    = '0;
        evt_en_d = evt_en_q;
        pulse_d  = '0;
        evt_clr  = '0;
        if (wr_c) begin
            for (int unsigned k = 0; k < NUM_CTRL; k++) begin
                if (idx_c == IW'(k)) begin
                    ctrl_d[k] = PWDATA;
                    stb_d[k]  = 1'b1;
                end
            end
            if (idx_c == IDX_EVT_EN) evt_en_d = PWDATA[NUM_EVT-1:0];
            if (idx_c == IDX_EVT_ST) evt_clr  = PWDATA[NUM_EVT-1:0];
            if (idx_c == IDX_PULSE)  pulse_d  = PWDATA;
        end
        evt_st_d = (evt_st_q & ~evt_clr) | evt_in;
        irq_d    = |(evt_st_q & evt_en_q);
        cnt_d    = (acc_c && !PREADY) ? cnt_q + CW'(1) : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_q   <= '0;
            stb_q    <= '0;
            evt_st_q <= '0;
            evt_en_q <= '0;
            pulse_q  <= '0;
            irq_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            stb_q    <= stb_d;
            evt_st_q <= evt_st_d;
            evt_en_q <= evt_en_d;
            pulse_q  <= pulse_d;
            irq_q    <= irq_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ctrl_out    = ctrl_q;
    assign ctrl_wr_stb = stb_q;
    assign pulse_out   = pulse_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_apb3_csr_bank.sv
// Bench for apb3_csr_bank: zero-wait and 3-wait instances driven with directed and
// random APB traffic, checked every cycle against a word-map model.
module tb_apb3_csr_bank;

    localparam int NC = 8;
    localparam int NS = 10;
    localparam int NE = 8;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int FW = NC * DW;
    localparam int IX_EST = NC + NS;
    localparam int IX_EEN = NC + NS + 1;
    localparam int IX_PUL = NC + NS + 2;
    localparam int IX_ID  = NC + NS + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn  [2];
    logic [AW-1:0] paddr   [2];
    logic          psel    [2];
    logic          penable [2];
    logic          pwrite  [2];
    logic [DW-1:0] pwdata  [2];
    logic          pready  [2];
    logic [DW-1:0] prdata  [2];
    logic          pslverr [2];
    logic [FW-1:0] ctrl_out[2];
    logic [NC-1:0] stb     [2];
    logic [NS*DW-1:0] stat_in [2];
    logic [NE-1:0] evt_in  [2];
    logic [NE-1:0] evt_force [2];
    logic [DW-1:0] pulse   [2];
    logic          irq     [2];
    logic          rand_evt;

    int total = 0;
    int bad   = 0;

    apb3_csr_bank #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .resetn(resetn[0]), .PADDR(paddr[0]), .PSEL(psel[0]),
        .PENABLE(penable[0]), .PWRITE(pwrite[0]), .PWDATA(pwdata[0]),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERROR(pslverr[0]),
        .ctrl_out(ctrl_out[0]), .ctrl_wr_stb(stb[0]), .stat_in(stat_in[0]),
        .evt_in(evt_in[0]), .pulse_out(pulse[0]), .irq(irq[0]));

    apb3_csr_bank #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .resetn(resetn[1]), .PADDR(paddr[1]), .PSEL(psel[1]),
        .PENABLE(penable[1]), .PWRITE(pwrite[1]), .PWDATA(pwdata[1]),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERROR(pslverr[1]),
        .ctrl_out(ctrl_out[1]), .ctrl_wr_stb(stb[1]), .stat_in(stat_in[1]),
        .evt_in(evt_in[1]), .pulse_out(pulse[1]), .irq(irq[1]));

    // Reference model state
    logic [DW-1:0] m_ctrl [2][NC];
    logic [NE-1:0] m_en   [2];
    logic [NE-1:0] m_st   [2];
    logic          m_irq  [2];
    logic [NC-1:0] m_stb  [2];
    logic [DW-1:0] m_pulse[2];
    int            m_wait [2];

    function automatic int ws(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    // What a read of address a returns and whether the access is an error.
    function automatic void mdec(input int i, input logic [AW-1:0] a, input logic w,
                                 output logic er, output logic [DW-1:0] d);
        int ix;
        ix = int'(a[AW-1:2]);
        er = 1'b0;
        d  = '0;
        if (a[1:0] != 2'b00 || ix > IX_ID) er = 1'b1;
        else if (ix < NC)       d = m_ctrl[i][ix];
        else if (ix < IX_EST) begin
            if (w) er = 1'b1;
            else   d = stat_in[i][(ix - NC) * DW +: DW];
        end
        else if (ix == IX_EST)  d = DW'(m_st[i]);
        else if (ix == IX_EEN)  d = DW'(m_en[i]);
        else if (ix == IX_ID) begin
            if (w) er = 1'b1;
            else   d = 32'hABCD_5678;
        end
        if (er) d = '0;
    endfunction

    task automatic chk(input string nm, input int i, input logic [FW-1:0] act,
                       input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[dut%0d]: got %h want %h", nm, i, act, exp);
        end
    endtask

    // Event drivers: random or directed, changed just after the rising edge.
    initial begin
        evt_in[0] = '0;
        evt_in[1] = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                evt_in[i] = rand_evt ? (($urandom % 3 == 0) ? NE'($urandom) : '0) : evt_force[i];
        end
    end

    // Model update at every rising edge.
    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!resetn[i]) begin
                for (int k = 0; k < NC; k++) m_ctrl[i][k] = '0;
                m_en[i] = '0; m_st[i] = '0; m_irq[i] = 1'b0;
                m_stb[i] = '0; m_pulse[i] = '0; m_wait[i] = 0;
            end else begin
                logic acc, rdy, er;
                logic [DW-1:0] d;
                logic [NE-1:0] clr;
                int ix;
                acc = psel[i] && penable[i];
                rdy = acc && (m_wait[i] == ws(i));
                mdec(i, paddr[i], pwrite[i], er, d);
                ix = int'(paddr[i][AW-1:2]);
                m_irq[i]   = |(m_st[i] & m_en[i]);
                m_stb[i]   = '0;
                m_pulse[i] = '0;
                clr        = '0;
                if (rdy && pwrite[i] && !er) begin
                    if (ix < NC) begin
                        m_ctrl[i][ix] = pwdata[i];
                        m_stb[i][ix]  = 1'b1;
                    end
                    else if (ix == IX_EST) clr = pwdata[i][NE-1:0];
                    else if (ix == IX_EEN) m_en[i] = pwdata[i][NE-1:0];
                    else if (ix == IX_PUL) m_pulse[i] = pwdata[i];
                end
                m_st[i]   = (m_st[i] & ~clr) | evt_in[i];
                m_wait[i] = (acc && !rdy) ? m_wait[i] + 1 : 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            if (resetn[i]) begin
                logic er, rdy;
                logic [DW-1:0] d;
                logic [FW-1:0] ec;
                mdec(i, paddr[i], pwrite[i], er, d);
                rdy = psel[i] && penable[i] && (m_wait[i] == ws(i));
                for (int k = 0; k < NC; k++) ec[k*DW +: DW] = m_ctrl[i][k];
                chk("pready",   i, FW'(pready[i]),  FW'(rdy));
                chk("pslverr",  i, FW'(pslverr[i]), FW'(rdy && er));
                chk("prdata",   i, FW'(prdata[i]),  FW'((rdy && !er) ? d : '0));
                chk("ctrl_out", i, ctrl_out[i],     ec);
                chk("ctrl_stb", i, FW'(stb[i]),     FW'(m_stb[i]));
                chk("pulse",    i, FW'(pulse[i]),   FW'(m_pulse[i]));
                chk("irq",      i, FW'(irq[i]),     FW'(m_irq[i]));
            end
        end
    end

    // One APB transfer; starts and ends just after a falling edge.
    task automatic xfer(input int i, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                        output logic er, output int n);
        rd = '0; er = 1'b0; n = 0;
        psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = wr; paddr[i] = a; pwdata[i] = wd;
        @(negedge clk);
        penable[i] = 1'b1;
        forever begin
            n++;
            #1;
            if (pready[i]) begin
                rd = prdata[i];
                er = pslverr[i];
                break;
            end
            if (n >= 20) begin
                total++; bad++;
                $display("FAIL pready_timeout[dut%0d]: got 0 want 1 within 20 access cycles", i);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        psel[i] = 1'b0; penable[i] = 1'b0;
    endtask

    function automatic logic [AW-1:0] wa(input int ix);
        return AW'(ix * 4);
    endfunction

    task automatic rand_traffic(input int i, input int cnt);
        logic [DW-1:0] rd;
        logic er;
        int n;
        for (int t = 0; t < cnt; t++) begin
            logic [AW-1:0] a;
            a = wa($urandom_range(0, IX_ID + 2));
            if ($urandom % 10 == 0) a[1:0] = 2'($urandom_range(1, 3));
            if ($urandom % 20 == 0) a = 12'hFFC;
            for (int j = 0; j < NS; j++) stat_in[i][j*DW +: DW] = $urandom;
            xfer(i, 1'($urandom % 2), a, $urandom, rd, er, n);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic er;
        int n;
        logic [FW-1:0] e;

        rand_evt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            resetn[i] = 1'b0; psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = '0; pwdata[i] = '0; stat_in[i] = '0; evt_force[i] = '0;
        end
        stat_in[0][2*DW +: DW] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ctrl_out", 0, ctrl_out[0], '0);
        chk("rst_irq",      0, FW'(irq[0]), '0);
        chk("rst_pready",   0, FW'(pready[0]), '0);
        chk("rst_pulse",    0, FW'(pulse[0]), '0);
        @(negedge clk);
        resetn[0] = 1'b1; resetn[1] = 1'b1;
        @(negedge clk);

        xfer(0, 1'b0, wa(IX_ID), '0, rd, er, n);
        chk("id_data",   0, FW'(rd), FW'(32'hABCD_5678));
        chk("id_err",    0, FW'(er), '0);
        chk("id_cycles", 0, FW'(n),  FW'(1));

        xfer(0, 1'b1, wa(3), 32'h1234_5678, rd, er, n);
        #1;
        e = '0;
        e[3*DW +: DW] = 32'h1234_5678;
        chk("ctrl3_word", 0, ctrl_out[0], e);
        chk("ctrl3_stb",  0, FW'(stb[0]), FW'(8'b0000_1000));
        @(negedge clk);
        #1;
        chk("ctrl3_stb_off", 0, FW'(stb[0]), '0);
        xfer(0, 1'b0, wa(3), '0, rd, er, n);
        chk("ctrl3_readback", 0, FW'(rd), FW'(32'h1234_5678));

        xfer(0, 1'b0, wa(NC + 2), '0, rd, er, n);
        chk("stat2_data", 0, FW'(rd), FW'(32'hDEAD_BEEF));
        xfer(0, 1'b1, wa(NC + 2), 32'h0BAD_F00D, rd, er, n);
        chk("stat2_wr_err", 0, FW'(er), FW'(1));
        xfer(0, 1'b0, 12'hFFC, '0, rd, er, n);
        chk("unmapped_err",  0, FW'(er), FW'(1));
        chk("unmapped_data", 0, FW'(rd), '0);

        xfer(0, 1'b1, wa(IX_EEN), 32'h0000_0005, rd, er, n);
        evt_force[0] = 8'h01;
        @(negedge clk);
        evt_force[0] = 8'h00;
        @(negedge clk);
        #1;
        chk("evt_irq_t1", 0, FW'(irq[0]), '0);
        @(negedge clk);
        #1;
        chk("evt_irq_t2", 0, FW'(irq[0]), FW'(1));
        evt_force[0] = 8'h01;
        repeat (2) @(negedge clk);
        xfer(0, 1'b1, wa(IX_EST), 32'h0000_0001, rd, er, n);
        xfer(0, 1'b0, wa(IX_EST), '0, rd, er, n);
        chk("w1c_held", 0, FW'(rd), FW'(1));
        evt_force[0] = 8'h00;
        repeat (2) @(negedge clk);
        xfer(0, 1'b1, wa(IX_EST), 32'h0000_0001, rd, er, n);
        repeat (2) @(negedge clk);
        #1;
        chk("w1c_irq_low", 0, FW'(irq[0]), '0);
        xfer(0, 1'b0, wa(IX_EST), '0, rd, er, n);
        chk("w1c_cleared", 0, FW'(rd), '0);

        xfer(0, 1'b1, wa(IX_PUL), 32'h0000_0003, rd, er, n);
        #1;
        chk("pulse_on", 0, FW'(pulse[0]), FW'(3));
        @(negedge clk);
        #1;
        chk("pulse_off", 0, FW'(pulse[0]), '0);
        xfer(0, 1'b0, wa(IX_PUL), '0, rd, er, n);
        chk("pulse_read", 0, FW'(rd), '0);

        // Three-wait instance: back-to-back transfers
        xfer(1, 1'b0, wa(IX_ID), '0, rd, er, n);
        chk("ws3_id_cycles", 1, FW'(n), FW'(4));
        chk("ws3_id_data",   1, FW'(rd), FW'(32'hABCD_5678));
        xfer(1, 1'b1, wa(0), 32'h5555_AAAA, rd, er, n);
        chk("ws3_wr_cycles", 1, FW'(n), FW'(4));
        xfer(1, 1'b0, wa(0), '0, rd, er, n);
        chk("ws3_rd_cycles", 1, FW'(n), FW'(4));
        chk("ws3_rd_data",   1, FW'(rd), FW'(32'h5555_AAAA));

        // Abort after two access cycles
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = wa(0);
        pwdata[1] = 32'h1111_1111;
        @(negedge clk);
        penable[1] = 1'b1;
        repeat (2) @(negedge clk);
        psel[1] = 1'b0; penable[1] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_ctrl0", 1, FW'(ctrl_out[1][DW-1:0]), FW'(32'h5555_AAAA));
        chk("abort_stb",   1, FW'(stb[1]), '0);

        rand_evt = 1'b1;
        rand_traffic(0, 250);
        rand_traffic(1, 120);
        rand_evt = 1'b0;
        repeat (2) @(negedge clk);

        // Reset asserted in the middle of a write access
        xfer(1, 1'b1, wa(IX_EEN), 32'h0000_00FF, rd, er, n);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = wa(1);
        pwdata[1] = 32'hCAFE_0001;
        @(negedge clk);
        penable[1] = 1'b1;
        @(negedge clk);
        #1;
        resetn[1] = 1'b0;
        #1;
        chk("rst_mid_ctrl",   1, ctrl_out[1], '0);
        chk("rst_mid_pready", 1, FW'(pready[1]), '0);
        chk("rst_mid_prdata", 1, FW'(prdata[1]), '0);
        chk("rst_mid_irq",    1, FW'(irq[1]), '0);
        chk("rst_mid_pulse",  1, FW'(pulse[1]), '0);
        chk("rst_mid_stb",    1, FW'(stb[1]), '0);
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn[1] = 1'b1;
        @(negedge clk);
        xfer(1, 1'b0, wa(1), '0, rd, er, n);
        chk("rst_mid_ctrl1_read", 1, FW'(rd), '0);
        xfer(1, 1'b0, wa(IX_EEN), '0, rd, er, n);
        chk("rst_mid_en_read", 1, FW'(rd), '0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
